// File: rtl/hpram_arbiter.sv
// rtl/hpram_arbiter.sv - two-port round-robin burst arbiter for the HyperRAM command interface
module hpram_arbiter #(
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 32,
    parameter int MASK_W      = 4,
    parameter int BURST_WORDS = 4,
    parameter int CMD_GAP     = 2,
    parameter int RD_TIMEOUT  = 64
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_init_calib,
    input  logic              I_req0,
    input  logic              I_cmd0,
    input  logic [ADDR_W-1:0] I_addr0,
    input  logic [DATA_W-1:0] I_wr_data0,
    input  logic [MASK_W-1:0] I_data_mask0,
    output logic              O_ack0,
    output logic              O_wdata_req0,
    output logic              O_rd_valid0,
    input  logic              I_req1,
    input  logic              I_cmd1,
    input  logic [ADDR_W-1:0] I_addr1,
    input  logic [DATA_W-1:0] I_wr_data1,
    input  logic [MASK_W-1:0] I_data_mask1,
    output logic              O_ack1,
    output logic              O_wdata_req1,
    output logic              O_rd_valid1,
    output logic [DATA_W-1:0] O_rd_data,
    output logic              O_cmd,
    output logic              O_cmd_en,
    output logic [ADDR_W-1:0] O_addr,
    output logic [DATA_W-1:0] O_wr_data,
    output logic [MASK_W-1:0] O_data_mask,
    input  logic              I_rd_data_valid,
    input  logic [DATA_W-1:0] I_rd_data,
    output logic              O_busy,
    output logic              O_timeout
);

    localparam int CNT_W = 5;
    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_CMD, S_WR, S_RD, S_GAP} state_t;

    // With no gap configured a finished burst returns straight to arbitration.
    localparam state_t AFTER_BURST = (CMD_GAP == 0) ? S_ARB : S_GAP;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              grant_q, grant_d;
    logic              cmd_q, cmd_d;
    logic              timeout_q, timeout_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              pick;
    logic              wr_phase;

    assign pick = (I_req0 && I_req1) ? ~ptr_q : I_req1;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b1;
            grant_q   <= 1'b0;
            cmd_q     <= 1'b0;
            timeout_q <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cmd_q     <= cmd_d;
            timeout_q <= timeout_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cmd_d     = cmd_q;
        timeout_d = timeout_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        if (!I_init_calib) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARB;
                S_ARB: begin
                    if (I_req0 || I_req1) begin
                        grant_d = pick;
                        ptr_d   = pick;
                        cmd_d   = pick ? I_cmd1 : I_cmd0;
                        addr_d  = pick ? I_addr1 : I_addr0;
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    cnt_d = '0;
                    tmo_d = TMO_W'(1);
                    if (cmd_q) begin
                        state_d = (BURST_WORDS == 1) ? AFTER_BURST : S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
                S_WR: begin
                    if (cnt_q == CNT_W'(BURST_WORDS - 2)) begin
                        state_d = AFTER_BURST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RD: begin
                    tmo_d = tmo_q + TMO_W'(1);
                    // A final beat landing on the last allowed cycle still completes cleanly.
                    if (I_rd_data_valid && cnt_q == CNT_W'(BURST_WORDS - 1)) begin
                        state_d = AFTER_BURST;
                        cnt_d   = '0;
                    end else if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = AFTER_BURST;
                        cnt_d     = '0;
                    end else if (I_rd_data_valid) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(CMD_GAP - 1)) begin
                        state_d = S_ARB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign wr_phase     = (state_q == S_CMD && cmd_q) || state_q == S_WR;
    assign O_cmd_en     = state_q == S_CMD;
    assign O_cmd        = cmd_q;
    assign O_addr       = addr_q;
    assign O_ack0       = O_cmd_en && !grant_q;
    assign O_ack1       = O_cmd_en && grant_q;
    assign O_wdata_req0 = wr_phase && !grant_q;
    assign O_wdata_req1 = wr_phase && grant_q;
    assign O_wr_data    = wr_phase ? (grant_q ? I_wr_data1 : I_wr_data0) : '0;
    assign O_data_mask  = wr_phase ? (grant_q ? I_data_mask1 : I_data_mask0) : '0;
    assign O_rd_data    = I_rd_data;
    assign O_rd_valid0  = I_rd_data_valid && state_q == S_RD && !grant_q;
    assign O_rd_valid1  = I_rd_data_valid && state_q == S_RD && grant_q;
    assign O_busy       = !(state_q == S_IDLE || state_q == S_ARB);
    assign O_timeout    = timeout_q;

endmodule

// File: tb/tb_hpram_arbiter.sv
// tb/tb_hpram_arbiter.sv - randomized directed bench for hpram_arbiter
module tb_hpram_arbiter;
    localparam int AW = 22, DW = 32, MW = 4, BW = 4, GAP = 2, TMO = 64;

    logic I_clk = 1'b0;
    logic I_rst, I_init_calib;
    logic I_req0, I_cmd0, I_req1, I_cmd1;
    logic [AW-1:0] I_addr0, I_addr1;
    logic [DW-1:0] I_wr_data0, I_wr_data1;
    logic [MW-1:0] I_data_mask0, I_data_mask1;
    logic O_ack0, O_wdata_req0, O_rd_valid0, O_ack1, O_wdata_req1, O_rd_valid1;
    logic [DW-1:0] O_rd_data, O_wr_data;
    logic O_cmd, O_cmd_en, O_busy, O_timeout;
    logic [AW-1:0] O_addr;
    logic [MW-1:0] O_data_mask;
    logic I_rd_data_valid;
    logic [DW-1:0] I_rd_data;

    hpram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .BURST_WORDS(BW),
                    .CMD_GAP(GAP), .RD_TIMEOUT(TMO)) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_init_calib(I_init_calib),
        .I_req0(I_req0), .I_cmd0(I_cmd0), .I_addr0(I_addr0), .I_wr_data0(I_wr_data0),
        .I_data_mask0(I_data_mask0), .O_ack0(O_ack0), .O_wdata_req0(O_wdata_req0),
        .O_rd_valid0(O_rd_valid0),
        .I_req1(I_req1), .I_cmd1(I_cmd1), .I_addr1(I_addr1), .I_wr_data1(I_wr_data1),
        .I_data_mask1(I_data_mask1), .O_ack1(O_ack1), .O_wdata_req1(O_wdata_req1),
        .O_rd_valid1(O_rd_valid1),
        .O_rd_data(O_rd_data), .O_cmd(O_cmd), .O_cmd_en(O_cmd_en), .O_addr(O_addr),
        .O_wr_data(O_wr_data), .O_data_mask(O_data_mask),
        .I_rd_data_valid(I_rd_data_valid), .I_rd_data(I_rd_data),
        .O_busy(O_busy), .O_timeout(O_timeout)
    );

    always #5 I_clk = ~I_clk;

    int errors = 0, checks = 0, cyc_n = 0;
    logic hold0, hold1;
    logic [DW-1:0] wbuf0[64], wbuf1[64];
    logic [MW-1:0] mbuf0[64], mbuf1[64];
    int widx0, widx1, eb0, eb1;
    int rv_sched[$];
    logic [AW-1:0] addr0_q[$], addr1_q[$];

    int cmd_cyc[$], wd_cyc[$], rv_cyc[$];
    logic [1:0] cmd_port[$], wd_port[$], rv_port[$];
    logic cmd_dir[$];
    logic [AW-1:0] cmd_addr[$];
    logic [DW-1:0] wd_data[$];
    logic [MW-1:0] wd_mask[$];
    int bad_ack, wd_leak, pass_bad;

    int e_cmd_cyc[$], e_wd_cyc[$], e_rv_cyc[$];
    logic [1:0] e_cmd_port[$], e_wd_port[$], e_rv_port[$];
    logic e_cmd_dir[$];
    logic [AW-1:0] e_cmd_addr[$];
    logic [DW-1:0] e_wd_data[$];
    logic [MW-1:0] e_wd_mask[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_out();
        return {28'b0, O_ack0, O_wdata_req0, O_rd_valid0, O_ack1, O_wdata_req1, O_rd_valid1,
                O_cmd, O_cmd_en, O_busy, O_timeout, O_addr, O_wr_data, O_data_mask, O_rd_data};
    endfunction

    task automatic drive_wdata();
        I_wr_data0   = wbuf0[widx0 % 64];
        I_data_mask0 = mbuf0[widx0 % 64];
        I_wr_data1   = wbuf1[widx1 % 64];
        I_data_mask1 = mbuf1[widx1 % 64];
    endtask

    task automatic clear_logs();
        cmd_cyc.delete(); cmd_port.delete(); cmd_dir.delete(); cmd_addr.delete();
        wd_cyc.delete(); wd_port.delete(); wd_data.delete(); wd_mask.delete();
        rv_cyc.delete(); rv_port.delete();
        e_cmd_cyc.delete(); e_cmd_port.delete(); e_cmd_dir.delete(); e_cmd_addr.delete();
        e_wd_cyc.delete(); e_wd_port.delete(); e_wd_data.delete(); e_wd_mask.delete();
        e_rv_cyc.delete(); e_rv_port.delete();
        addr0_q.delete(); addr1_q.delete();
        bad_ack = 0; wd_leak = 0; pass_bad = 0;
        widx0 = 0; widx1 = 0; eb0 = 0; eb1 = 0;
        for (int i = 0; i < 64; i++) begin
            wbuf0[i] = $urandom(); wbuf1[i] = $urandom();
            mbuf0[i] = MW'($urandom()); mbuf1[i] = MW'($urandom());
        end
        drive_wdata();
        #1;
    endtask

    task automatic sample();
        if (O_cmd_en === 1'b1) begin
            cmd_cyc.push_back(cyc_n); cmd_port.push_back({O_ack1, O_ack0});
            cmd_dir.push_back(O_cmd); cmd_addr.push_back(O_addr);
        end else if (O_ack0 === 1'b1 || O_ack1 === 1'b1) bad_ack++;
        if (O_wdata_req0 === 1'b1 || O_wdata_req1 === 1'b1) begin
            wd_cyc.push_back(cyc_n); wd_port.push_back({O_wdata_req1, O_wdata_req0});
            wd_data.push_back(O_wr_data); wd_mask.push_back(O_data_mask);
        end else if (O_wr_data !== '0 || O_data_mask !== '0) wd_leak++;
        if (O_rd_valid0 === 1'b1 || O_rd_valid1 === 1'b1) begin
            rv_cyc.push_back(cyc_n); rv_port.push_back({O_rd_valid1, O_rd_valid0});
        end
        if (O_rd_data !== I_rd_data) pass_bad++;
    endtask

    task automatic tick();
        logic a0, a1, d0, d1;
        sample();
        a0 = O_ack0 === 1'b1; a1 = O_ack1 === 1'b1;
        d0 = O_wdata_req0 === 1'b1; d1 = O_wdata_req1 === 1'b1;
        @(posedge I_clk); #1;
        cyc_n++;
        if (d0) widx0++;
        if (d1) widx1++;
        drive_wdata();
        if (a0) begin
            if (hold0) begin I_addr0 = AW'($urandom()); addr0_q.push_back(I_addr0); end
            else I_req0 = 1'b0;
        end
        if (a1) begin
            if (hold1) begin I_addr1 = AW'($urandom()); addr1_q.push_back(I_addr1); end
            else I_req1 = 1'b0;
        end
        I_rd_data_valid = 1'b0;
        if (rv_sched.size() > 0 && rv_sched[0] == cyc_n) begin
            I_rd_data_valid = 1'b1;
            void'(rv_sched.pop_front());
        end
        I_rd_data = $urandom();
        #1;
    endtask

    task automatic run_to(input int target);
        while (cyc_n < target) tick();
    endtask

    task automatic do_reset();
        I_rst = 1'b1; I_init_calib = 1'b0; I_req0 = 1'b0; I_req1 = 1'b0;
        I_cmd0 = 1'b0; I_cmd1 = 1'b0; I_rd_data_valid = 1'b0;
        hold0 = 1'b0; hold1 = 1'b0;
        rv_sched.delete();
        tick(); tick();
        I_rd_data = '0;
        #1;
    endtask

    // Expected command plus the write words the requester's buffer should supply for it.
    task automatic exp_cmd(input int c, input int port, input logic dir, input logic [AW-1:0] addr,
                           input int nw);
        e_cmd_cyc.push_back(c); e_cmd_port.push_back(port == 1 ? 2'b10 : 2'b01);
        e_cmd_dir.push_back(dir); e_cmd_addr.push_back(addr);
        if (dir) begin
            for (int i = 0; i < nw; i++) begin
                e_wd_cyc.push_back(c + i);
                e_wd_port.push_back(port == 1 ? 2'b10 : 2'b01);
                e_wd_data.push_back(port == 1 ? wbuf1[eb1 * BW + i] : wbuf0[eb0 * BW + i]);
                e_wd_mask.push_back(port == 1 ? mbuf1[eb1 * BW + i] : mbuf0[eb0 * BW + i]);
            end
            if (port == 1) eb1++; else eb0++;
        end
    endtask

    task automatic exp_rv(input int c, input int port);
        e_rv_cyc.push_back(c); e_rv_port.push_back(port == 1 ? 2'b10 : 2'b01);
    endtask

    task automatic compare_logs(input string name);
        check({name, "_ncmd"}, cmd_cyc.size(), e_cmd_cyc.size());
        foreach (e_cmd_cyc[i]) if (i < cmd_cyc.size()) begin
            check({name, "_cmd_cyc"}, cmd_cyc[i], e_cmd_cyc[i]);
            check({name, "_cmd_ack"}, cmd_port[i], e_cmd_port[i]);
            check({name, "_cmd_dir"}, cmd_dir[i], e_cmd_dir[i]);
            check({name, "_cmd_addr"}, cmd_addr[i], e_cmd_addr[i]);
        end
        check({name, "_nwd"}, wd_cyc.size(), e_wd_cyc.size());
        foreach (e_wd_cyc[i]) if (i < wd_cyc.size()) begin
            check({name, "_wd_cyc"}, wd_cyc[i], e_wd_cyc[i]);
            check({name, "_wd_port"}, wd_port[i], e_wd_port[i]);
            check({name, "_wd_data"}, wd_data[i], e_wd_data[i]);
            check({name, "_wd_mask"}, wd_mask[i], e_wd_mask[i]);
        end
        check({name, "_nrv"}, rv_cyc.size(), e_rv_cyc.size());
        foreach (e_rv_cyc[i]) if (i < rv_cyc.size()) begin
            check({name, "_rv_cyc"}, rv_cyc[i], e_rv_cyc[i]);
            check({name, "_rv_port"}, rv_port[i], e_rv_port[i]);
        end
        check({name, "_stray_ack"}, bad_ack, 0);
        check({name, "_wdata_leak"}, wd_leak, 0);
        check({name, "_rd_passthru"}, pass_bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, t, k, m, n, o, a, k0, k1;
        logic ptr, g;
        I_rst = 1'b1; I_init_calib = 1'b0; I_req0 = 1'b0; I_req1 = 1'b0;
        I_cmd0 = 1'b0; I_cmd1 = 1'b0; I_addr0 = '0; I_addr1 = '0;
        I_rd_data_valid = 1'b0; I_rd_data = '0; hold0 = 1'b0; hold1 = 1'b0;
        clear_logs();

        do_reset();
        check("reset_outputs", all_out(), '0);
        check("reset_timeout", O_timeout, 1'b0);

        // Calibration gating, then a port 0 write followed by a port 1 read with gapped returns.
        clear_logs();
        I_req0 = 1'b1; I_cmd0 = 1'b1; I_addr0 = 22'h000100; addr0_q.push_back(I_addr0);
        I_rst = 1'b0; #1;
        repeat (20) tick();
        check("gate_no_cmd", cmd_cyc.size(), 0);
        check("gate_busy", O_busy, 1'b0);
        c = cyc_n; I_init_calib = 1'b1; #1;
        run_to(c + 2);
        check("calib_cmd_en", O_cmd_en, 1'b1);
        check("calib_ack0", O_ack0, 1'b1);
        t = c + 1;
        run_to(t + 2);
        I_req1 = 1'b1; I_cmd1 = 1'b0; I_addr1 = 22'h3FFFFF; addr1_q.push_back(I_addr1); #1;
        rv_sched.push_back(t + 4);
        o = 0;
        for (int i = 0; i < BW; i++) begin
            o += $urandom_range(1, 8);
            rv_sched.push_back(t + 8 + o);
            exp_rv(t + 8 + o, 1);
        end
        run_to(t + 7);
        check("wr_next_arb", O_busy, 1'b0);
        run_to(t + 60);
        exp_cmd(t + 1, 0, 1'b1, addr0_q[0], BW);
        exp_cmd(t + 1 + BW + GAP + 1, 1, 1'b0, addr1_q[0], 0);
        compare_logs("wr_rd");

        // Round robin with both ports holding write requests.
        do_reset();
        clear_logs();
        I_init_calib = 1'b1; I_req0 = 1'b1; I_req1 = 1'b1; I_cmd0 = 1'b1; I_cmd1 = 1'b1;
        I_addr0 = AW'($urandom()); addr0_q.push_back(I_addr0);
        I_addr1 = AW'($urandom()); addr1_q.push_back(I_addr1);
        hold0 = 1'b1; hold1 = 1'b1;
        I_rst = 1'b0; #1;
        a = cyc_n + 1;
        run_to(a + 3 * (1 + BW + GAP) + 1);
        hold1 = 1'b0; I_req0 = 1'b0; #1;
        run_to(a + 45);
        ptr = 1'b1; k0 = 0; k1 = 0;
        for (int i = 0; i < 4; i++) begin
            g = ~ptr; ptr = g;
            exp_cmd(a + 1 + i * (1 + BW + GAP), int'(g), 1'b1, g ? addr1_q[k1] : addr0_q[k0], BW);
            if (g) k1++; else k0++;
        end
        compare_logs("rr");

        // Read timeout with only two returns, then a stray beat in ARB.
        do_reset();
        clear_logs();
        I_init_calib = 1'b1; I_req0 = 1'b1; I_cmd0 = 1'b0;
        I_addr0 = AW'($urandom()); addr0_q.push_back(I_addr0);
        I_rst = 1'b0; #1;
        k = cyc_n + 2;
        o = $urandom_range(1, 20);
        rv_sched.push_back(k + o); exp_rv(k + o, 0);
        o += $urandom_range(1, 20);
        rv_sched.push_back(k + o); exp_rv(k + o, 0);
        rv_sched.push_back(k + TMO + 8);
        run_to(k + TMO - 1);
        check("tmo_not_yet", O_timeout, 1'b0);
        check("tmo_busy_rd", O_busy, 1'b1);
        run_to(k + TMO);
        check("tmo_set", O_timeout, 1'b1);
        check("tmo_busy_gap", O_busy, 1'b1);
        run_to(k + TMO + GAP);
        check("tmo_back_arb", O_busy, 1'b0);
        run_to(k + TMO + 12);
        check("tmo_sticky", O_timeout, 1'b1);
        exp_cmd(k, 0, 1'b0, addr0_q[0], 0);
        compare_logs("tmo");

        // Calibration lost during the third write word.
        clear_logs();
        I_req0 = 1'b1; I_cmd0 = 1'b1; I_addr0 = AW'($urandom()); addr0_q.push_back(I_addr0); #1;
        m = cyc_n + 1;
        run_to(m + 2);
        I_init_calib = 1'b0; #1;
        check("drop_wreq_live", O_wdata_req0, 1'b1);
        check("drop_word2", O_wr_data, wbuf0[2]);
        run_to(m + 3);
        check("drop_cmd_en", O_cmd_en, 1'b0);
        check("drop_wreq", O_wdata_req0, 1'b0);
        check("drop_idle", O_busy, 1'b0);
        check("drop_tmo_held", O_timeout, 1'b1);
        run_to(m + 6);
        I_init_calib = 1'b1; #1;
        run_to(m + 20);
        exp_cmd(m, 0, 1'b1, addr0_q[0], 3);
        compare_logs("drop");

        // Reset asserted while a port 1 read is in flight.
        clear_logs();
        I_req1 = 1'b1; I_cmd1 = 1'b0; I_addr1 = AW'($urandom()); addr1_q.push_back(I_addr1); #1;
        n = cyc_n + 1;
        rv_sched.push_back(n + 2); exp_rv(n + 2, 1);
        run_to(n + 3);
        check("midrst_busy_rd", O_busy, 1'b1);
        I_rst = 1'b1; #1;
        tick();
        I_rd_data = '0; #1;
        check("midrst_outputs", all_out(), '0);
        check("midrst_timeout", O_timeout, 1'b0);
        I_rst = 1'b0;
        exp_cmd(n, 1, 1'b0, addr1_q[0], 0);
        compare_logs("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
